// File: rtl/mod_regread_if.sv
// Decode, writeback and execute-side handshake bundle for the operand-fetch stage.
// The stage itself is the slave; the decoder/writeback/execute harness is the master.
interface mod_regread_if #(
    parameter int IW = 4
);
    logic          dec_valid;
    logic          dec_ready;
    logic [7:0]    dec_opcode;
    logic          dec_twob;
    logic          dec_src1_en;
    logic [IW-1:0] dec_src1_idx;
    logic          dec_src2_en;
    logic [IW-1:0] dec_src2_idx;
    logic          dec_dst_en;
    logic [IW-1:0] dec_dst_idx;
    logic          dec_rsp_upd;
    logic [63:0]   dec_imm;

    logic          wb_valid;
    logic          wb_dst_en;
    logic [IW-1:0] wb_dst_idx;
    logic          wb_rsp_upd;
    logic [63:0]   wb_dst_data;

    logic          rr_valid;
    logic          rr_ready;
    logic [7:0]    rr_opcode;
    logic          rr_twob;
    logic          rr_dst_en;
    logic [IW-1:0] rr_dst_idx;
    logic          rr_rsp_upd;
    logic [63:0]   rr_imm;
    logic [63:0]   rr_op1;
    logic [63:0]   rr_op2;

    modport master (
        output dec_valid, dec_opcode, dec_twob, dec_src1_en, dec_src1_idx,
               dec_src2_en, dec_src2_idx, dec_dst_en, dec_dst_idx, dec_rsp_upd, dec_imm,
               wb_valid, wb_dst_en, wb_dst_idx, wb_rsp_upd, wb_dst_data, rr_ready,
        input  dec_ready, rr_valid, rr_opcode, rr_twob, rr_dst_en, rr_dst_idx,
               rr_rsp_upd, rr_imm, rr_op1, rr_op2
    );

    modport slave (
        input  dec_valid, dec_opcode, dec_twob, dec_src1_en, dec_src1_idx,
               dec_src2_en, dec_src2_idx, dec_dst_en, dec_dst_idx, dec_rsp_upd, dec_imm,
               wb_valid, wb_dst_en, wb_dst_idx, wb_rsp_upd, wb_dst_data, rr_ready,
        output dec_ready, rr_valid, rr_opcode, rr_twob, rr_dst_en, rr_dst_idx,
               rr_rsp_upd, rr_imm, rr_op1, rr_op2
    );
endinterface

// File: rtl/mod_regread.sv
// Operand fetch with per-register RAW scoreboard; 1-cycle latency; decode stalls on hazard or full slot.
// Optional same-cycle writeback bypass is enabled by defining REGREAD_BYPASS_EN.
module mod_regread #(
    parameter int NREG    = 16,
    parameter int SB_W    = 2,
    parameter int RSP_IDX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NREG-1:0][63:0] regfile,
    mod_regread_if.slave          bus,
    output logic                  sb_busy
);
    localparam int              IW     = $clog2(NREG);
    localparam int              CW     = SB_W + 2;
    localparam logic [IW-1:0]   RSP    = IW'(RSP_IDX);
    localparam logic [SB_W-1:0] SB_MAX = '1;

    logic [NREG-1:0][SB_W-1:0] sb_q, sb_d;
    logic                      sb_busy_q, sb_busy_d;
    logic                      rr_valid_q;
    logic [7:0]                rr_opcode_q;
    logic                      rr_twob_q, rr_dst_en_q, rr_rsp_upd_q;
    logic [IW-1:0]             rr_dst_idx_q;
    logic [63:0]               rr_imm_q, rr_op1_q, rr_op2_q;

    logic        slot_free, hazard, ovf, accept, byp1, byp2;
    logic [63:0] op1_d, op2_d;
    logic [1:0]  inc, dec;
    logic [CW-1:0] sum;

    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
`ifdef REGREAD_BYPASS_EN
        // Only an explicit-destination retirement carries data; RSP-only retirement is never forwarded.
        byp1 = bus.wb_valid && bus.wb_dst_en && (bus.wb_dst_idx == bus.dec_src1_idx)
               && (sb_q[bus.dec_src1_idx] == SB_W'(1));
        byp2 = bus.wb_valid && bus.wb_dst_en && (bus.wb_dst_idx == bus.dec_src2_idx)
               && (sb_q[bus.dec_src2_idx] == SB_W'(1));
`endif
        slot_free = !rr_valid_q || bus.rr_ready;

        ovf = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc = 2'(bus.dec_dst_en && (bus.dec_dst_idx == IW'(r)))
                + 2'(bus.dec_rsp_upd && (RSP == IW'(r)));
            sum = CW'(sb_q[r]) + CW'(inc);
            if (sum > CW'(SB_MAX)) ovf = 1'b1;
        end

        hazard = (bus.dec_src1_en && (sb_q[bus.dec_src1_idx] != '0) && !byp1)
              || (bus.dec_src2_en && (sb_q[bus.dec_src2_idx] != '0) && !byp2)
              || ovf;
        bus.dec_ready = slot_free && !hazard && !flush;
        accept        = bus.dec_valid && bus.dec_ready;

        op1_d = !bus.dec_src1_en ? 64'd0 : (byp1 ? bus.wb_dst_data : regfile[bus.dec_src1_idx]);
        op2_d = !bus.dec_src2_en ? 64'd0 : (byp2 ? bus.wb_dst_data : regfile[bus.dec_src2_idx]);

        // Net per-register change; a decrement below zero clamps at zero.
        sb_busy_d = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc = accept ? 2'(bus.dec_dst_en && (bus.dec_dst_idx == IW'(r)))
                         + 2'(bus.dec_rsp_upd && (RSP == IW'(r))) : 2'd0;
            dec = bus.wb_valid ? 2'(bus.wb_dst_en && (bus.wb_dst_idx == IW'(r)))
                               + 2'(bus.wb_rsp_upd && (RSP == IW'(r))) : 2'd0;
            sum = CW'(sb_q[r]) + CW'(inc);
            if (flush)                  sb_d[r] = '0;
            else if (CW'(dec) > sum)    sb_d[r] = '0;
            else                        sb_d[r] = SB_W'(sum - CW'(dec));
            if (sb_d[r] != '0) sb_busy_d = 1'b1;
        end
    end

`ifndef REGREAD_BYPASS_EN
    logic unused_wb_data;
    assign unused_wb_data = ^bus.wb_dst_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q          <= '0;
            sb_busy_q     <= 1'b0;
            rr_valid_q    <= 1'b0;
            rr_opcode_q   <= '0;
            rr_twob_q     <= 1'b0;
            rr_dst_en_q   <= 1'b0;
            rr_dst_idx_q  <= '0;
            rr_rsp_upd_q  <= 1'b0;
            rr_imm_q      <= '0;
            rr_op1_q      <= '0;
            rr_op2_q      <= '0;
        end else begin
            sb_q      <= sb_d;
            sb_busy_q <= sb_busy_d;
            if (flush) begin
                rr_valid_q <= 1'b0;
            end else if (accept) begin
                rr_valid_q   <= 1'b1;
                rr_opcode_q  <= bus.dec_opcode;
                rr_twob_q    <= bus.dec_twob;
                rr_dst_en_q  <= bus.dec_dst_en;
                rr_dst_idx_q <= bus.dec_dst_idx;
                rr_rsp_upd_q <= bus.dec_rsp_upd;
                rr_imm_q     <= bus.dec_imm;
                rr_op1_q     <= op1_d;
                rr_op2_q     <= op2_d;
            end else if (bus.rr_ready) begin
                rr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rr_valid   = rr_valid_q;
    assign bus.rr_opcode  = rr_opcode_q;
    assign bus.rr_twob    = rr_twob_q;
    assign bus.rr_dst_en  = rr_dst_en_q;
    assign bus.rr_dst_idx = rr_dst_idx_q;
    assign bus.rr_rsp_upd = rr_rsp_upd_q;
    assign bus.rr_imm     = rr_imm_q;
    assign bus.rr_op1     = rr_op1_q;
    assign bus.rr_op2     = rr_op2_q;
    assign sb_busy        = sb_busy_q;
endmodule
